wb_gpmc_master: RTL and testbench

WB_GPMC_MASTER -- requirements
Module: wb_gpmc_master

---
 rtl/wb_gpmc_master.sv | 191 +++++++++++++++++++
 tb/tb_wb_gpmc_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpmc_master.sv
// wb_gpmc_master
//   Wishbone slave that turns each single-beat request into one asynchronous
//   GPMC bus cycle with programmable setup / strobe / hold phases, then
//   returns a one-cycle wb_ack_o.
//
// Parameters
//   SETUP_CYC    (1..15)  address/NCS setup cycles before the strobe
//   STROBE_CYC   (1..15)  NWE/NOE low cycles
//   HOLD_CYC     (0..15)  cycles after the strobe with NCS and data held
//   WAIT_TIMEOUT (1..255) maximum wait-extension cycles (wait feature only)
//
// Ports
//   wb_clk, wb_rst            clock, asynchronous active-high reset
//   wb_adr_i[10:0]            byte address (bit 0 ignored)
//   wb_dat_i / wb_dat_o       write data / captured read data
//   wb_sel_i[1:0]             byte lanes
//   wb_cyc_i/stb_i/we_i       request, wb_ack_o single-cycle completion
//   GPMC_A[9:0]               word address (wb_adr_i[10:1])
//   GPMC_D_out/D_in/D_oe      split data bus and its output enable
//   GPMC_NBE[1:0]             active-low byte enables
//   GPMC_NCS/NWE/NOE          active-low controls
//
// Build option
//   WB_GPMC_WAIT_EN  adds GPMC_WAIT (in, active-high, 2-flop synchronised)
//                    and wait_timeout (out, sticky until wb_rst). While the
//                    synchronised wait is high after STROBE_CYC has elapsed,
//                    the strobe is extended for at most WAIT_TIMEOUT cycles.

module wb_gpmc_master #(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 1,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [10:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [9:0]  GPMC_A,
  output logic [15:0] GPMC_D_out,
  input  logic [15:0] GPMC_D_in,
  output logic        GPMC_D_oe,
  output logic [1:0]  GPMC_NBE,
  output logic        GPMC_NCS,
  output logic        GPMC_NWE,
  output logic        GPMC_NOE
`ifdef WB_GPMC_WAIT_EN
  ,
  input  logic        GPMC_WAIT,
  output logic        wait_timeout
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] ACK    = 3'd4;

  // Counters load "phase length - 1" and count down to zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 0 || HOLD_CYC > 15 || WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255)
  begin : g_bad_param
    $error("wb_gpmc_master: timing parameter out of range");
  end

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [9:0]  adr_q;
  logic [15:0] dat_q;
  logic [1:0]  sel_q;
  logic        we_q;
  logic        abort_q;  // master dropped cyc during this access
  logic        active;
  logic        extend;
  logic        unused_adr0;

  assign unused_adr0 = wb_adr_i[0];

`ifdef WB_GPMC_WAIT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);

  logic [1:0] wait_sync;
  logic [7:0] ext_cnt;

  assign extend = wait_sync[1] && (ext_cnt != WAIT_LIMIT);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wait_sync    <= '0;
      ext_cnt      <= '0;
      wait_timeout <= 1'b0;
    end else begin
      wait_sync <= {wait_sync[0], GPMC_WAIT};
      // SETUP always precedes STROBE, so clearing here reloads on entry.
      if (state == SETUP)
        ext_cnt <= '0;
      else if (state == STROBE && cnt == '0 && extend)
        ext_cnt <= ext_cnt + 8'd1;
      if (state == STROBE && cnt == '0 && wait_sync[1] && ext_cnt == WAIT_LIMIT)
        wait_timeout <= 1'b1;
    end
  end
`else
  assign extend = 1'b0;
`endif

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      abort_q  <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            adr_q   <= wb_adr_i[10:1];
            dat_q   <= wb_dat_i;
            sel_q   <= wb_sel_i;
            we_q    <= wb_we_i;
            abort_q <= 1'b0;
            cnt     <= SETUP_LD;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= STROBE_LD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (!extend) begin
            if (!we_q)
              wb_dat_o <= GPMC_D_in;
            if (HOLD_CYC == 0) begin
              cnt   <= '0;
              state <= ACK;
            end else begin
              cnt   <= HOLD_LD;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt == '0)
            state <= ACK;
          else
            cnt <= cnt - 4'd1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (state != IDLE && !wb_cyc_i)
        abort_q <= 1'b1;
    end
  end

  always_comb begin
    active     = (state == SETUP) || (state == STROBE) || (state == HOLD);
    GPMC_NCS   = !active;
    GPMC_A     = adr_q;
    GPMC_D_out = dat_q;
    GPMC_NBE   = active ? ~sel_q : 2'b11;
    GPMC_D_oe  = active && we_q;
    GPMC_NWE   = !(state == STROBE && we_q);
    GPMC_NOE   = !(state == STROBE && !we_q);
    wb_ack_o   = (state == ACK) && !abort_q && wb_cyc_i;
  end

endmodule

// File: tb/tb_wb_gpmc_master.sv
// tb_wb_gpmc_master
//   Directed bench for wb_gpmc_master with default timing (2/4/1). With
//   WB_GPMC_WAIT_EN defined it also exercises the wait timeout with
//   WAIT_TIMEOUT=8.

module tb_wb_gpmc_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [10:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic        wb_ack_o;
  logic [9:0]  GPMC_A;
  logic [15:0] GPMC_D_out;
  logic [15:0] GPMC_D_in;
  logic        GPMC_D_oe;
  logic [1:0]  GPMC_NBE;
  logic        GPMC_NCS, GPMC_NWE, GPMC_NOE;
`ifdef WB_GPMC_WAIT_EN
  logic        GPMC_WAIT;
  logic        wait_timeout;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 wb_clk = ~wb_clk;

  wb_gpmc_master #(
    .SETUP_CYC(2),
    .STROBE_CYC(4),
    .HOLD_CYC(1),
`ifdef WB_GPMC_WAIT_EN
    .WAIT_TIMEOUT(8)
`else
    .WAIT_TIMEOUT(255)
`endif
  ) dut (
    .wb_clk(wb_clk),
    .wb_rst(wb_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o),
    .GPMC_A(GPMC_A),
    .GPMC_D_out(GPMC_D_out),
    .GPMC_D_in(GPMC_D_in),
    .GPMC_D_oe(GPMC_D_oe),
    .GPMC_NBE(GPMC_NBE),
    .GPMC_NCS(GPMC_NCS),
    .GPMC_NWE(GPMC_NWE),
    .GPMC_NOE(GPMC_NOE)
`ifdef WB_GPMC_WAIT_EN
    ,
    .GPMC_WAIT(GPMC_WAIT),
    .wait_timeout(wait_timeout)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One access: request presented at a negedge, accepted on the next posedge
  // (cycle 0). Cycles 1..24 after the accept edge are sampled at negedges.
  // GPMC_D_in carries din only while NOE is low, 0xDEAD otherwise, so a
  // capture outside the strobe is visible. drop_at>0 drops cyc/stb then.
  task automatic do_access(
    input  logic        we,
    input  logic [10:0] adr,
    input  logic [15:0] dat,
    input  logic [1:0]  sel,
    input  logic [15:0] din,
    input  int          drop_at,
    output int          ack_at,
    output int          acks,
    output int          nwe_low,
    output int          noe_low,
    output int          ncs_low,
    output int          oe_cyc,
    output logic [9:0]  a_s,
    output logic [1:0]  nbe_s,
    output logic [15:0] dout_s,
    output logic [15:0] rdat);
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    GPMC_D_in = 16'hDEAD;
    @(posedge wb_clk);
    ack_at = -1; acks = 0; nwe_low = 0; noe_low = 0; ncs_low = 0; oe_cyc = 0;
    a_s = '0; nbe_s = '0; dout_s = '0; rdat = '0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge wb_clk);
      if (!GPMC_NWE) nwe_low++;
      if (!GPMC_NOE) noe_low++;
      if (!GPMC_NCS) ncs_low++;
      if (GPMC_D_oe) oe_cyc++;
      if (i == 1) begin
        a_s = GPMC_A; nbe_s = GPMC_NBE; dout_s = GPMC_D_out;
      end
      if (wb_ack_o) begin
        acks++;
        if (ack_at < 0) begin
          ack_at = i;
          rdat = wb_dat_o;
          wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
      end
      if (i == drop_at) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      GPMC_D_in = GPMC_NOE ? 16'hDEAD : din;
    end
  endtask

  int          ack_at, acks, nwe_low, noe_low, ncs_low, oe_cyc;
  logic [9:0]  a_s;
  logic [1:0]  nbe_s;
  logic [15:0] dout_s, rdat;
  int          a1, a2, gap;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wb_rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    GPMC_D_in = '0;
`ifdef WB_GPMC_WAIT_EN
    GPMC_WAIT = 1'b0;
`endif

    // Reset values
    repeat (2) @(negedge wb_clk);
    check_eq("rst_ncs", 32'(GPMC_NCS), 32'd1);
    check_eq("rst_nwe", 32'(GPMC_NWE), 32'd1);
    check_eq("rst_noe", 32'(GPMC_NOE), 32'd1);
    check_eq("rst_oe", 32'(GPMC_D_oe), 32'd0);
    check_eq("rst_nbe", 32'(GPMC_NBE), 32'h3);
    check_eq("rst_a", 32'(GPMC_A), 32'h0);
    check_eq("rst_dout", 32'(GPMC_D_out), 32'h0);
    check_eq("rst_dat_o", 32'(wb_dat_o), 32'h0);
    check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
`ifdef WB_GPMC_WAIT_EN
    check_eq("rst_wait_timeout", 32'(wait_timeout), 32'd0);
`endif
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);

    // Write 0x2A4 <- 0xBEEF, both lanes
    do_access(1'b1, 11'h2A4, 16'hBEEF, 2'b11, 16'h0000, 0,
              ack_at, acks, nwe_low, noe_low, ncs_low, oe_cyc, a_s, nbe_s, dout_s, rdat);
    check_eq("wr_a", 32'(a_s), 32'h152);
    check_eq("wr_nbe", 32'(nbe_s), 32'h0);
    check_eq("wr_dout", 32'(dout_s), 32'hBEEF);
    check_eq("wr_oe_cycles", 32'(oe_cyc), 32'd7);
    check_eq("wr_nwe_low", 32'(nwe_low), 32'd4);
    check_eq("wr_noe_low", 32'(noe_low), 32'd0);
    check_eq("wr_ncs_low", 32'(ncs_low), 32'd7);
    check_eq("wr_ack_at", 32'(ack_at), 32'd8);
    check_eq("wr_ack_count", 32'(acks), 32'd1);

    // Read 0x010, upper lane only, D_in 0x1234 during the strobe
    do_access(1'b0, 11'h010, 16'h0000, 2'b10, 16'h1234, 0,
              ack_at, acks, nwe_low, noe_low, ncs_low, oe_cyc, a_s, nbe_s, dout_s, rdat);
    check_eq("rd_a", 32'(a_s), 32'h008);
    check_eq("rd_nbe", 32'(nbe_s), 32'h1);
    check_eq("rd_oe_cycles", 32'(oe_cyc), 32'd0);
    check_eq("rd_noe_low", 32'(noe_low), 32'd4);
    check_eq("rd_nwe_low", 32'(nwe_low), 32'd0);
    check_eq("rd_ack_at", 32'(ack_at), 32'd8);
    check_eq("rd_data", 32'(rdat), 32'h1234);

    // Write to top address, low lane: read data must be held
    do_access(1'b1, 11'h7FF, 16'h00A5, 2'b01, 16'h0000, 0,
              ack_at, acks, nwe_low, noe_low, ncs_low, oe_cyc, a_s, nbe_s, dout_s, rdat);
    check_eq("wr2_a", 32'(a_s), 32'h3FF);
    check_eq("wr2_nbe", 32'(nbe_s), 32'h2);
    check_eq("wr2_dout", 32'(dout_s), 32'h00A5);
    check_eq("wr2_ack_at", 32'(ack_at), 32'd8);
    check_eq("rd_data_held", 32'(wb_dat_o), 32'h1234);

    // cyc dropped in the strobe: full strobe, no ack
    do_access(1'b1, 11'h044, 16'h7777, 2'b11, 16'h0000, 4,
              ack_at, acks, nwe_low, noe_low, ncs_low, oe_cyc, a_s, nbe_s, dout_s, rdat);
    check_eq("abort_nwe_low", 32'(nwe_low), 32'd4);
    check_eq("abort_ncs_low", 32'(ncs_low), 32'd7);
    check_eq("abort_ack_count", 32'(acks), 32'd0);
    check_eq("abort_idle_ncs", 32'(GPMC_NCS), 32'd1);

    // Back-to-back write then read with stb held through the ack.
    // NCS stays high for the ACK cycle and the IDLE accept cycle that
    // follows it; the read's accept edge closes that IDLE cycle.
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 11'h100; wb_dat_i = 16'h5A5A; wb_sel_i = 2'b11;
    GPMC_D_in = 16'hDEAD;
    @(posedge wb_clk);
    a1 = -1; a2 = -1; gap = 0; rdat = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge wb_clk);
      if (wb_ack_o) begin
        if (a1 < 0) begin
          a1 = i;
          wb_we_i = 1'b0; wb_adr_i = 11'h102;
        end else if (a2 < 0) begin
          a2 = i;
          rdat = wb_dat_o;
          wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
      end
      if (a1 >= 0 && a2 < 0 && GPMC_NCS) gap++;
      GPMC_D_in = GPMC_NOE ? 16'hDEAD : 16'hC0DE;
    end
    check_eq("b2b_first_ack", 32'(a1), 32'd8);
    check_eq("b2b_second_ack", 32'(a2), 32'd17);
    check_eq("b2b_ncs_high_gap", 32'(gap), 32'd2);
    check_eq("b2b_rd_data", 32'(rdat), 32'hC0DE);

    // Reset in the middle of the strobe
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 11'h0AA; wb_dat_i = 16'h1111; wb_sel_i = 2'b11;
    @(posedge wb_clk);
    repeat (4) @(negedge wb_clk);
    check_eq("pre_rst_nwe", 32'(GPMC_NWE), 32'd0);
    wb_rst = 1'b1;
    #1;
    check_eq("mid_rst_ncs", 32'(GPMC_NCS), 32'd1);
    check_eq("mid_rst_nwe", 32'(GPMC_NWE), 32'd1);
    check_eq("mid_rst_noe", 32'(GPMC_NOE), 32'd1);
    check_eq("mid_rst_oe", 32'(GPMC_D_oe), 32'd0);
    check_eq("mid_rst_a", 32'(GPMC_A), 32'h0);
    check_eq("mid_rst_ack", 32'(wb_ack_o), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    do_access(1'b0, 11'h3C0, 16'h0000, 2'b11, 16'h4321, 0,
              ack_at, acks, nwe_low, noe_low, ncs_low, oe_cyc, a_s, nbe_s, dout_s, rdat);
    check_eq("post_rst_ack_at", 32'(ack_at), 32'd8);
    check_eq("post_rst_a", 32'(a_s), 32'h1E0);
    check_eq("post_rst_data", 32'(rdat), 32'h4321);

`ifdef WB_GPMC_WAIT_EN
    // WAIT stuck high: 4 + 8 strobe cycles, then normal completion
    check_eq("wait_timeout_clear", 32'(wait_timeout), 32'd0);
    GPMC_WAIT = 1'b1;
    repeat (3) @(negedge wb_clk);
    do_access(1'b1, 11'h020, 16'h2468, 2'b11, 16'h0000, 0,
              ack_at, acks, nwe_low, noe_low, ncs_low, oe_cyc, a_s, nbe_s, dout_s, rdat);
    check_eq("wait_nwe_low", 32'(nwe_low), 32'd12);
    check_eq("wait_ack_at", 32'(ack_at), 32'd16);
    check_eq("wait_ack_count", 32'(acks), 32'd1);
    check_eq("wait_timeout_set", 32'(wait_timeout), 32'd1);
    GPMC_WAIT = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
